// File: rtl/sram_like_pkg.sv
// Shared constants and helpers for the sram-like responder.
// Latency: none; only types, constants and a pure function live here.
// Backpressure: not applicable.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting towards the MSB
    localparam int             LFSR_W    = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    // Delay counters hold configured delay plus up to 3 cycles of jitter
    localparam int DLY_W = 4;
    typedef logic [DLY_W-1:0] dly_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// Request/addr_ok/data_ok bus between an initiator and the responder.
// Latency: wires only.
// Backpressure: addr_ok throttles requests; data_ok cannot be stalled.
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder_resp_fifo.sv
// Small synchronous FIFO holding response words in issue order.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty.
module resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign head_dat = store[rd_ptr];

    // Payload storage needs no reset; count qualifies it
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_dat;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sram_like_responder.sv
// Word-organised on-chip RAM answering the sram-like bus strictly in order.
// Latency: response DATA_DELAY(+jitter) cycles after reaching queue head; read data sampled at handshake.
// Backpressure: addr_ok low during ADDR_DELAY gap or while response queue full; data_ok never stalls.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int          MEM_AW      = 12,
    parameter int          OUTSTANDING = 2,
    parameter int          ADDR_DELAY  = 0,
    parameter int          DATA_DELAY  = 0,
    parameter int          RAND_EN     = 0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  resetn,
    sram_like_responder_if.slave  bus
);
    localparam int CW = $clog2(OUTSTANDING + 1);

    logic [31:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0] widx;
    logic [LFSR_W-1:0] lfsr;
    dly_t              jitter;
    dly_t              addr_cnt;
    dly_t              head_cnt;
    logic              hs;
    logic              pop;
    logic              load_head;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
    logic [31:0]       head_dat;
    logic [31:0]       push_dat;
    logic              unused_ok;

    // Upper and byte-offset address bits alias; size is informational only
    assign unused_ok = ^{bus.addr[31:MEM_AW+2], bus.addr[1:0], bus.size};

    assign widx     = bus.addr[MEM_AW+1:2];
    assign jitter   = (RAND_EN != 0) ? dly_t'(lfsr[1:0]) : '0;

    // addr_ok depends only on registered state, never on req
    assign bus.addr_ok = (addr_cnt == '0) & ~full;
    assign hs          = bus.req & bus.addr_ok;

    // Writes answer with zero; reads capture the word as it stands before this edge
    assign push_dat = bus.wr ? 32'h0 : mem[widx];

    assign bus.data_ok = ~empty & (head_cnt == '0);
    assign pop         = bus.data_ok;
    assign bus.rdata   = bus.data_ok ? head_dat : 32'h0;

    // A new head appears on push into empty, or on pop when another entry remains or arrives
    assign load_head = (hs & empty) | (pop & ((count > CW'(1)) | hs));

    resp_fifo #(
        .WIDTH (32),
        .DEPTH (OUTSTANDING),
        .CW    (CW)
    ) u_resp_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (hs),
        .push_dat (push_dat),
        .pop      (pop),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .head_dat (head_dat)
    );

    // Byte-strobed write commit at the accepting edge; contents survive reset
    always_ff @(posedge clk) begin
        if (hs && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    // Jitter source advances every cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= LFSR_SEED;
        else         lfsr <= lfsr_next(lfsr);
    end

    // Idle gap after each handshake before addr_ok may return
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              addr_cnt <= '0;
        else if (hs)              addr_cnt <= dly_t'(ADDR_DELAY) + jitter;
        else if (addr_cnt != '0)  addr_cnt <= addr_cnt - 1'b1;
    end

    // Countdown of the current queue head before it is released
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              head_cnt <= '0;
        else if (load_head)       head_cnt <= dly_t'(DATA_DELAY) + jitter;
        else if (head_cnt != '0)  head_cnt <= head_cnt - 1'b1;
    end
endmodule
